// File: rtl/bcd_digit_reader.sv
// Captures a packed BCD value and streams its digits MSB first over a valid/ready handshake.
// Optional leading-zero blanking is enabled by defining BCD_LEADING_ZERO_BLANK_EN.
module bcd_digit_reader #(
  parameter int DIGITS = 8
) (
  input  logic                      clk_in,
  input  logic                      reset_in,
  input  logic                      start_in,
  input  logic [4*DIGITS-1:0]       bcd_in,
  output logic                      busy_out,
  output logic                      digit_valid_out,
  input  logic                      digit_ready_in,
  output logic [3:0]                digit_out,
  output logic [$clog2(DIGITS)-1:0] index_out,
  output logic                      last_out,
  output logic                      blank_out,
  output logic                      error_out,
  output logic                      done_out
);

  localparam int IDXW = $clog2(DIGITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      bad = bad | (v[4*k +: 4] > 4'd9);
    end
    return bad;
  endfunction

  function automatic logic [3:0] digit_at(input logic [4*DIGITS-1:0] v, input logic [IDXW-1:0] idx);
    return v[{idx, 2'b00} +: 4];
  endfunction

  // Non-decimal codes are reported through error_out and shown as zero.
  function automatic logic [3:0] sanitize(input logic [3:0] d);
    return (d > 4'd9) ? 4'd0 : d;
  endfunction

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] cap_q, cap_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic                error_q, error_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic [3:0]          digit_q, digit_d;
  logic [IDXW-1:0]     out_index_q, out_index_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic [3:0]          raw_d;
`ifdef BCD_LEADING_ZERO_BLANK_EN
  // run: every digit above the current one was zero
  logic                run_q, run_d;
  logic                blank_q, blank_d;
`endif

  // Next-state logic; outputs are computed from the next state so they register alongside it.
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    idx_d   = idx_q;
    error_d = error_q;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    run_d   = run_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = EMIT;
          cap_d   = bcd_in;
          idx_d   = IDXW'(DIGITS - 1);
          error_d = has_bad_digit(bcd_in);
`ifdef BCD_LEADING_ZERO_BLANK_EN
          run_d   = 1'b1;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (digit_ready_in) begin
          if (idx_q == {IDXW{1'b0}}) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q - IDXW'(1);
`ifdef BCD_LEADING_ZERO_BLANK_EN
            run_d = run_q && (digit_at(cap_q, idx_q) == 4'd0);
`endif
          end
        end else begin
          state_d = EMIT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    raw_d       = digit_at(cap_d, idx_d);
    valid_d     = (state_d == EMIT);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    digit_d     = valid_d ? sanitize(raw_d) : 4'd0;
    out_index_d = valid_d ? idx_d : {IDXW{1'b0}};
    last_d      = valid_d && (idx_d == {IDXW{1'b0}});
`ifdef BCD_LEADING_ZERO_BLANK_EN
    blank_d     = valid_d && run_d && (raw_d == 4'd0) && (idx_d != {IDXW{1'b0}});
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q     <= IDLE;
      cap_q       <= {(4*DIGITS){1'b0}};
      idx_q       <= {IDXW{1'b0}};
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      digit_q     <= 4'd0;
      out_index_q <= {IDXW{1'b0}};
      last_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef BCD_LEADING_ZERO_BLANK_EN
      run_q       <= 1'b0;
      blank_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      idx_q       <= idx_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      digit_q     <= digit_d;
      out_index_q <= out_index_d;
      last_q      <= last_d;
      done_q      <= done_d;
`ifdef BCD_LEADING_ZERO_BLANK_EN
      run_q       <= run_d;
      blank_q     <= blank_d;
`endif
    end
  end

  assign busy_out        = busy_q;
  assign digit_valid_out = valid_q;
  assign digit_out       = digit_q;
  assign index_out       = out_index_q;
  assign last_out        = last_q;
  assign error_out       = error_q;
  assign done_out        = done_q;
`ifdef BCD_LEADING_ZERO_BLANK_EN
  assign blank_out       = blank_q;
`else
  assign blank_out       = 1'b0;
`endif

endmodule
